// File: rtl/ws2812b_pulse_encoder.sv
// WS2812B serial encoder: shifts 24-bit GRB pixels out MSB first as fixed-period
// high/low pulses on dout, and emits the low reset/latch code on request.
module ws2812b_pulse_encoder #(
    parameter int CLK_HZ       = 64000000,
    parameter int T0H_CYCLES   = 26,
    parameter int T1H_CYCLES   = 51,
    parameter int BIT_CYCLES   = 80,
    parameter int RESET_CYCLES = 3200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic        latch,
    output logic        busy,
    output logic        dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam logic [11:0] T0H_W   = 12'(T0H_CYCLES);
    localparam logic [11:0] T1H_W   = 12'(T1H_CYCLES);
    localparam logic [11:0] BIT_W   = 12'(BIT_CYCLES);
    localparam logic [11:0] RESET_W = 12'(RESET_CYCLES);

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic [23:0] shreg_q, shreg_d;
    logic        latch_pending_q, latch_pending_d;
    logic        dout_q, dout_d;

    logic [11:0] th_s;
    logic [11:0] tl_s;
    logic        bit_end_s;
    logic        pixel_end_s;
    logic        latch_req_s;
    logic        accept_s;

    // Bit timing, handshake and status decode from the current state.
    always_comb begin
        th_s        = shreg_q[23] ? T1H_W : T0H_W;
        tl_s        = BIT_W - th_s;
        bit_end_s   = (state_q == LOW) && (cnt_q == tl_s - 12'd1);
        pixel_end_s = bit_end_s && (bit_idx_q == 5'd0);
        latch_req_s = latch_pending_q || latch;
        pixel_ready = ((state_q == IDLE) || pixel_end_s) && !latch_pending_q && !latch;
        accept_s    = pixel_valid && pixel_ready;
        busy        = (state_q != IDLE) || latch_pending_q;
        dout        = dout_q;
    end

    // Next-state logic; dout_d always reflects the state being entered.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q + 12'd1;
        bit_idx_d       = bit_idx_q;
        shreg_d         = shreg_q;
        latch_pending_d = latch_pending_q || (latch && (state_q != LATCH));
        dout_d          = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 12'd0;
                if (latch_req_s) begin
                    state_d         = LATCH;
                    latch_pending_d = 1'b0;
                end else if (accept_s) begin
                    state_d   = HIGH;
                    shreg_d   = pixel_data;
                    bit_idx_d = 5'd23;
                    dout_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HIGH: begin
                if (cnt_q == th_s - 12'd1) begin
                    state_d = LOW;
                    cnt_d   = 12'd0;
                end else begin
                    dout_d = 1'b1;
                end
            end
            LOW: begin
                if (!bit_end_s) begin
                    dout_d = 1'b0;
                end else if (bit_idx_q != 5'd0) begin
                    state_d   = HIGH;
                    cnt_d     = 12'd0;
                    bit_idx_d = bit_idx_q - 5'd1;
                    shreg_d   = {shreg_q[22:0], 1'b0};
                    dout_d    = 1'b1;
                end else if (latch_req_s) begin
                    // A pending latch wins the pixel boundary; never cuts a pixel short.
                    state_d         = LATCH;
                    cnt_d           = 12'd0;
                    latch_pending_d = 1'b0;
                end else if (accept_s) begin
                    state_d   = HIGH;
                    cnt_d     = 12'd0;
                    shreg_d   = pixel_data;
                    bit_idx_d = 5'd23;
                    dout_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 12'd0;
                end
            end
            LATCH: begin
                if (cnt_q != RESET_W - 12'd1) begin
                    state_d = LATCH;
                end else if (latch_pending_q) begin
                    cnt_d           = 12'd0;
                    latch_pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 12'd0;
                end
            end
            default: begin
                state_d         = IDLE;
                cnt_d           = 12'd0;
                bit_idx_d       = 5'd0;
                shreg_d         = 24'd0;
                latch_pending_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= 12'd0;
            bit_idx_q       <= 5'd0;
            shreg_q         <= 24'd0;
            latch_pending_q <= 1'b0;
            dout_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shreg_q         <= shreg_d;
            latch_pending_q <= latch_pending_d;
            dout_q          <= dout_d;
        end
    end

endmodule

// File: tb/tb_ws2812b_pulse_encoder.sv
// Self-checking bench for ws2812b_pulse_encoder: waveforms are compared against an
// expected dout sequence built from the pixel bits and the nominal pulse timings.
module tb_ws2812b_pulse_encoder;

    localparam int T0H  = 26;
    localparam int T1H  = 51;
    localparam int BITC = 80;
    localparam int RSTC = 3200;
    localparam int PIXC = 24 * BITC;
    localparam int THR  = 38;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        latch;
    logic        busy;
    logic        dout;

    int total  = 0;
    int passed = 0;

    logic [23:0] tx_q[$];
    logic        dbuf[$];
    logic        bbuf[$];
    logic        exp_q[$];
    logic        dec_q[$];
    logic        bits_q[$];
    int          acc_k[$];
    int          latch_at = -1;

    ws2812b_pulse_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_data (pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .latch      (latch),
        .busy       (busy),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_pixel(input logic [23:0] p);
        for (int b = 23; b >= 0; b--) begin
            bits_q.push_back(p[b]);
            for (int c = 0; c < BITC; c++) exp_q.push_back(c < (p[b] ? T1H : T0H));
        end
    endfunction

    function automatic void add_latch();
        for (int c = 0; c < RSTC; c++) exp_q.push_back(1'b0);
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= dbuf.size()) return i;
            if (dbuf[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic int tail_highs();
        int n = 0;
        for (int i = exp_q.size(); i < dbuf.size(); i++) if (dbuf[i] !== 1'b0) n++;
        return n;
    endfunction

    // Receiver model: one decoded bit per high pulse, '1' when the pulse is long.
    function automatic void decode();
        int run = 0;
        dec_q.delete();
        foreach (dbuf[i]) begin
            if (dbuf[i] === 1'b1) run++;
            else if (run > 0) begin
                dec_q.push_back(run >= THR);
                run = 0;
            end
        end
    endfunction

    // Offers tx_q pixels continuously; dbuf[k]/bbuf[k] hold dout/busy after edge k.
    task automatic stream(input int ncyc);
        int idx = 0;
        dbuf.delete(); bbuf.delete(); acc_k.delete();
        for (int k = 0; k < ncyc; k++) begin
            latch = (k == latch_at);
            if (idx < tx_q.size()) begin
                pixel_valid = 1'b1;
                pixel_data  = tx_q[idx];
            end else begin
                pixel_valid = 1'b0;
                pixel_data  = 24'($urandom);
            end
            #1;
            if (pixel_valid && pixel_ready) begin
                acc_k.push_back(k);
                idx++;
            end
            step();
            dbuf.push_back(dout);
            bbuf.push_back(busy);
        end
        pixel_valid = 1'b0;
        latch       = 1'b0;
        latch_at    = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pixel_valid = 1'b0; latch = 1'b0; pixel_data = 24'h0;
        repeat (3) step();
        reset = 1'b0;
        step();
        total++; if (dout !== 1'b0) $display("FAIL reset_dout got %b want 0", dout); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (pixel_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", pixel_ready); else passed++;
    endtask

    task automatic test_single_pixel();
        int d;
        tx_q = '{24'h800000};
        exp_q.delete(); bits_q.delete();
        add_pixel(24'h800000);
        stream(PIXC + 6);
        d = first_diff();
        total++; if (acc_k.size() != 1 || acc_k[0] != 0) $display("FAIL single_accept got %0d accepts want 1 at k=0", acc_k.size()); else passed++;
        total++; if (dbuf[0] !== 1'b1) $display("FAIL single_latency got %b want 1", dbuf[0]); else passed++;
        total++; if (d >= 0) $display("FAIL single_wave cycle %0d got %b want %b", d, dbuf[d], exp_q[d]); else passed++;
        total++; if (tail_highs() != 0) $display("FAIL single_tail got %0d high cycles want 0", tail_highs()); else passed++;
        total++; if (bbuf[PIXC-1] !== 1'b1 || bbuf[PIXC] !== 1'b0) $display("FAIL single_busy got %b%b want 10", bbuf[PIXC-1], bbuf[PIXC]); else passed++;
    endtask

    task automatic test_back_to_back();
        int d;
        tx_q = '{24'hFFFFFF, 24'h000000};
        exp_q.delete(); bits_q.delete();
        add_pixel(24'hFFFFFF);
        add_pixel(24'h000000);
        stream(2 * PIXC + 6);
        d = first_diff();
        total++; if (acc_k.size() != 2) $display("FAIL b2b_accepts got %0d want 2", acc_k.size()); else passed++;
        total++; if (acc_k.size() == 2 && acc_k[1] != PIXC) $display("FAIL b2b_second_accept got %0d want %0d", acc_k[1], PIXC); else passed++;
        total++; if (d >= 0) $display("FAIL b2b_wave cycle %0d got %b want %b", d, dbuf[d], exp_q[d]); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_latch_with_pixel();
        logic [23:0] p;
        int bad = 0;
        int d;
        p = 24'($urandom);
        latch = 1'b1; pixel_valid = 1'b1; pixel_data = p;
        #1;
        total++; if (pixel_ready !== 1'b0) $display("FAIL latchpix_ready got %b want 0", pixel_ready); else passed++;
        step();
        latch = 1'b0;
        for (int i = 0; i < RSTC; i++) begin
            if (dout !== 1'b0 || busy !== 1'b1) bad++;
            #1;
            if (pixel_ready !== 1'b0) bad++;
            step();
        end
        total++; if (bad != 0) $display("FAIL latchpix_hold got %0d bad cycles want 0", bad); else passed++;
        tx_q = '{p};
        exp_q.delete(); bits_q.delete();
        add_pixel(p);
        stream(PIXC + 4);
        d = first_diff();
        total++; if (acc_k.size() != 1 || acc_k[0] != 0) $display("FAIL latchpix_start got %0d accepts want 1 at k=0", acc_k.size()); else passed++;
        total++; if (d >= 0) $display("FAIL latchpix_wave cycle %0d got %b want %b", d, dbuf[d], exp_q[d]); else passed++;
    endtask

    task automatic test_latch_midpixel();
        logic [23:0] p;
        int d;
        int bad = 0;
        p = 24'($urandom);
        tx_q = '{p};
        exp_q.delete(); bits_q.delete();
        add_pixel(p);
        add_latch();
        latch_at = 13 * BITC + 40;
        stream(PIXC + RSTC + 6);
        d = first_diff();
        for (int i = 0; i < PIXC + RSTC; i++) if (bbuf[i] !== 1'b1) bad++;
        total++; if (d >= 0) $display("FAIL midlatch_wave cycle %0d got %b want %b", d, dbuf[d], exp_q[d]); else passed++;
        total++; if (bad != 0) $display("FAIL midlatch_busy got %0d low cycles want 0", bad); else passed++;
        total++; if (bbuf[PIXC + RSTC] !== 1'b0) $display("FAIL midlatch_idle got busy=%b want 0", bbuf[PIXC + RSTC]); else passed++;
        total++; if (tail_highs() != 0) $display("FAIL midlatch_tail got %0d high cycles want 0", tail_highs()); else passed++;
    endtask

    task automatic test_reset_midbit();
        int highs = 0;
        tx_q = '{24'($urandom) | 24'h800000};
        stream(30);
        total++; if (dbuf[29] !== 1'b1) $display("FAIL rstmid_pre got %b want 1", dbuf[29]); else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (dout !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_abort got dout=%b busy=%b want 0 0", dout, busy); else passed++;
        #1;
        total++; if (pixel_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", pixel_ready); else passed++;
        for (int i = 0; i < 200; i++) begin
            step();
            if (dout !== 1'b0) highs++;
        end
        total++; if (highs != 0) $display("FAIL rstmid_quiet got %0d high cycles want 0", highs); else passed++;
    endtask

    task automatic test_loopback();
        int d;
        int bad = 0;
        tx_q.delete(); exp_q.delete(); bits_q.delete();
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(24'($urandom));
            add_pixel(tx_q[i]);
        end
        stream(3 * PIXC + 6);
        d = first_diff();
        decode();
        for (int i = 0; i < 3; i++) if (i >= acc_k.size() || acc_k[i] != i * PIXC) bad++;
        total++; if (bad != 0) $display("FAIL loop_accepts got %0d wrong accept slots want 0", bad); else passed++;
        total++; if (d >= 0) $display("FAIL loop_wave cycle %0d got %b want %b", d, dbuf[d], exp_q[d]); else passed++;
        total++; if (dec_q.size() != bits_q.size()) $display("FAIL loop_bitcount got %0d want %0d", dec_q.size(), bits_q.size()); else passed++;
        bad = 0;
        foreach (bits_q[i]) if (i >= dec_q.size() || dec_q[i] !== bits_q[i]) bad++;
        total++; if (bad != 0) $display("FAIL loop_bits got %0d wrong bits want 0", bad); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_latch_with_pixel();
        test_latch_midpixel();
        test_reset_midbit();
        test_loopback();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ws2812b_pulse_encoder.md
WS2812B_PULSE_ENCODER -- requirements
Module: ws2812b_pulse_encoder

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- CLK_HZ, 64000000, clock frequency in Hz (documentation only).
- T0H_CYCLES, 26, high time of a '0' bit in clocks (about 0.40 us).
- T1H_CYCLES, 51, high time of a '1' bit in clocks (about 0.80 us).
- BIT_CYCLES, 80, total bit period in clocks (1.25 us).
- RESET_CYCLES, 3200, latch (reset-code) low time in clocks (50 us).
REQ-002 Parameter legality SHALL be 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES, BIT_CYCLES <= 4095, and RESET_CYCLES <= 4095; behaviour outside these limits is undefined.
REQ-003 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- pixel_data, input, 24, pixel word; [23:16]=G, [15:8]=R, [7:0]=B.
- pixel_valid, input, 1, pixel_data is valid.
- pixel_ready, output, 1, block accepts pixel_data this cycle.
- latch, input, 1, one-cycle request to emit the reset/latch code.
- busy, output, 1, a transmission or latch is in progress or pending.
- dout, output, 1, registered serial line to the first LED DIN.

Function
REQ-004 A pixel SHALL be accepted on any rising edge where pixel_valid && pixel_ready; pixel_data SHALL be captured into a 24-bit shift register on that edge.
REQ-005 Bits SHALL be sent MSB first (bit 23 first), 24 bits per pixel.
REQ-006 The state machine SHALL have four states: IDLE, HIGH, LOW and LATCH.
REQ-007 In IDLE, dout SHALL be 0.
REQ-008 IDLE SHALL go to LATCH when a latch is pending, else to HIGH on a pixel accept, else stay in IDLE.
REQ-009 For each bit, dout SHALL be 1 for Th cycles, where Th = T1H_CYCLES if the bit is 1 and T0H_CYCLES if the bit is 0.
REQ-010 After the high time, dout SHALL be 0 for BIT_CYCLES - Th cycles, so every bit period is exactly BIT_CYCLES.
REQ-011 Latency SHALL be one cycle: after an accept on edge N, dout SHALL be 1 from cycle N+1.
REQ-012 From LOW, the state machine SHALL go to HIGH for the next bit; after bit 0 it SHALL go to HIGH (new pixel accepted), else LATCH (latch pending), else IDLE.
REQ-013 pixel_ready SHALL be combinational and equal to (state==IDLE || last LOW cycle of bit 0) && !latch_pending && !latch.
REQ-014 Because of REQ-013, consecutive pixels SHALL be sent back to back with no gap beyond the normal bit period.
REQ-015 A latch pulse SHALL set a sticky latch_pending flag in any state except LATCH.
REQ-016 A latch pulse while in LATCH SHALL be ignored.
REQ-017 latch_pending SHALL be cleared on entry to LATCH.
REQ-018 At a pixel boundary, a pending latch SHALL take priority over pixel_valid; a latch and pixel_valid in the same cycle SHALL result in the latch being sent first, and the pixel SHALL not be accepted that cycle.
REQ-019 In LATCH, dout SHALL be 0 for exactly RESET_CYCLES cycles, after which the state SHALL return to IDLE (or to LATCH again if a new latch is pending).
REQ-020 A latch request SHALL never truncate a pixel in flight; it is serviced only after bit 0 completes.
REQ-021 busy SHALL be (state != IDLE) || latch_pending.
REQ-022 The cycle counter SHALL be 12 bits and the bit index 5 bits; neither SHALL wrap during legal operation.
REQ-023 pixel_data SHALL be ignored when no accept occurs; changes to pixel_data after an accept SHALL not affect the pixel being sent.

Reset
REQ-024 When reset is high on a rising edge, the block SHALL, on that edge: go to IDLE, set dout=0, clear latch_pending, clear the counters and the shift register.
REQ-025 After reset, pixel_ready SHALL be 1 (with latch low) and busy SHALL be 0.
REQ-026 Reset SHALL take precedence over all other inputs.
REQ-027 Reset during HIGH, LOW or LATCH SHALL abort immediately, and dout SHALL be 0 from the next cycle.

Verification
REQ-028 Single pixel 0x800000 from IDLE: dout high 51 / low 29; then 23 x (high 26 / low 54); then IDLE, busy=0 after 1920 cycles.
REQ-029 Pixels 0xFFFFFF then 0x000000 held valid: 48 contiguous 80-cycle periods (24 x 51-high, then 24 x 26-high); second accept occurs on the last LOW cycle of the first pixel.
REQ-030 latch and pixel_valid asserted together in IDLE: dout low 3200 cycles, pixel_ready=0 throughout; then the pixel starts with no extra gap; busy=1 throughout.
REQ-031 latch pulse at mid-bit 10: the pixel completes all 24 bits, then 3200 low cycles, then IDLE.
REQ-032 reset asserted at cycle 30 of a '1' bit: dout=0 on the next cycle, pixel_ready=1, busy=0, and no further pulses.
REQ-033 Loopback into the team's WS2812B pulse decoder (THRESHOLD_CYCLES=38) with random pixels: the decoded bit_value stream SHALL equal the sent bits MSB first, with no missing or extra bit_valid pulses.
